// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared raster constants, coordinate type and sprite enums
package vga_pkg;

    localparam int COORD_W   = 10;
    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic {
        MODE_WINDOWED = 1'b0,
        MODE_FULL     = 1'b1
    } screen_mode_t;

    typedef enum logic {
        HS_IDLE    = 1'b0,
        HS_PENDING = 1'b1
    } hs_state_t;

    function automatic logic is_frame_start(input coord_t h, input coord_t v);
        return (h == '0) && (v == '0);
    endfunction

endpackage

// File: rtl/ROM_Sprite.sv
// rtl/ROM_Sprite.sv - synchronous sprite bitmap ROM, one row per word, 1-cycle read
module ROM_Sprite
    import vga_pkg::*;
#(
    parameter int SPR_W  = 200,
    parameter int SPR_H  = 145,
    parameter int ADDR_W = $clog2(SPR_H)
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [SPR_W-1:0]  data
);

    // Checkerboard bitmap: pixel lit when row+col is even, column 0 in bit 0.
    function automatic logic [SPR_W-1:0] row_pattern(input logic [ADDR_W-1:0] r);
        logic [SPR_W-1:0] w;
        w = '0;
        for (int c = 0; c < SPR_W; c++) begin
            w[c] = ~(r[0] ^ c[0]);
        end
        return w;
    endfunction

    always_ff @(posedge clk) begin
        data <= row_pattern(addr);
    end

endmodule

// File: rtl/object_sprite.sv
// rtl/object_sprite.sv - positioned sprite overlay with frame-synced offset update; blink via OBJECT_SPRITE_BLINK_EN
module object_sprite
    import vga_pkg::*;
#(
    parameter int SPR_W        = 200,
    parameter int SPR_H        = 145,
    parameter int WIN_X        = 6,
    parameter int WIN_Y        = 26,
    parameter int FULL_X       = 214,
    parameter int FULL_Y       = 172,
    parameter int BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] HCount,
    input  logic [COORD_W-1:0] VCount,
    input  logic               sprite_select,
    input  logic               full_screen,
    input  logic               pos_valid,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    output logic               pos_ready,
    output logic               sprite_on
);

    localparam int ROW_W = $clog2(SPR_H);
    localparam int COL_W = $clog2(SPR_W);

    logic         frame_start;
    hs_state_t    hs_state;
    coord_t       shadow_x, shadow_y;
    coord_t       off_x, off_y;
    screen_mode_t mode_l;
    logic         sel_l;

    assign frame_start = is_frame_start(HCount, VCount);

    // Offsets only change at frame start so a frame is never drawn with a torn position.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_state  <= HS_IDLE;
            pos_ready <= 1'b1;
            shadow_x  <= '0;
            shadow_y  <= '0;
            off_x     <= '0;
            off_y     <= '0;
            mode_l    <= MODE_WINDOWED;
            sel_l     <= 1'b1;
        end else begin
            if (frame_start) begin
                mode_l <= full_screen ? MODE_FULL : MODE_WINDOWED;
                sel_l  <= sprite_select;
            end
            case (hs_state)
                HS_IDLE: begin
                    if (pos_valid) begin
                        shadow_x  <= pos_x;
                        shadow_y  <= pos_y;
                        pos_ready <= 1'b0;
                        hs_state  <= HS_PENDING;
                    end
                end
                HS_PENDING: begin
                    if (frame_start) begin
                        off_x     <= shadow_x;
                        off_y     <= shadow_y;
                        pos_ready <= 1'b1;
                        hs_state  <= HS_IDLE;
                    end
                end
                default: begin
                    hs_state  <= HS_IDLE;
                    pos_ready <= 1'b1;
                end
            endcase
        end
    end

    logic [10:0] base_x, base_y, org_x, org_y;
    logic [11:0] end_x, end_y, h_ext, v_ext;
    logic [10:0] row_full, col_full;
    logic        in_x, in_y, hit, mask;
    logic [ROW_W-1:0] rom_addr;

    always_comb begin
        base_x   = (mode_l == MODE_FULL) ? 11'(FULL_X) : 11'(WIN_X);
        base_y   = (mode_l == MODE_FULL) ? 11'(FULL_Y) : 11'(WIN_Y);
        org_x    = base_x + {1'b0, off_x};
        org_y    = base_y + {1'b0, off_y};
        end_x    = {1'b0, org_x} + 12'(SPR_W - 1);
        end_y    = {1'b0, org_y} + 12'(SPR_H - 1);
        h_ext    = {2'b00, HCount};
        v_ext    = {2'b00, VCount};
        in_x     = (h_ext >= {1'b0, org_x}) && (h_ext <= end_x) && (HCount < COORD_W'(H_VISIBLE));
        in_y     = (v_ext >= {1'b0, org_y}) && (v_ext <= end_y) && (VCount < COORD_W'(V_VISIBLE));
        hit      = in_x && in_y;
        row_full = {1'b0, VCount} - org_y;
        col_full = {1'b0, HCount} - org_x;
        mask     = (mode_l == MODE_FULL) && !sel_l;
        rom_addr = hit ? row_full[ROW_W-1:0] : '0;
    end

    logic [SPR_W-1:0] rom_data;

    ROM_Sprite #(
        .SPR_W  (SPR_W),
        .SPR_H  (SPR_H),
        .ADDR_W (ROW_W)
    ) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    logic             visible;

`ifdef OBJECT_SPRITE_BLINK_EN
    logic [$clog2(BLINK_FRAMES+1)-1:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
            visible   <= 1'b1;
        end else if (frame_start) begin
            if (frame_cnt == ($bits(frame_cnt))'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                visible   <= ~visible;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
`else
    assign visible = 1'b1;
`endif

    logic             hit_d, mask_d;
    logic [COL_W-1:0] col_d;

    // Stage 1 aligns hit/col/mask with the ROM read; stage 2 picks the column bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_d     <= 1'b0;
            mask_d    <= 1'b0;
            col_d     <= '0;
            sprite_on <= 1'b0;
        end else begin
            hit_d     <= hit;
            mask_d    <= mask;
            col_d     <= col_full[COL_W-1:0];
            sprite_on <= hit_d & rom_data[col_d] & ~mask_d & visible;
        end
    end

endmodule
